// File: rtl/ddr3_avl_arbiter.sv
// Two-port round-robin burst arbiter in front of a DDR3 Avalon-MM port.
// Outstanding read bursts are tagged so returning beats are steered to their issuer.
module ddr3_avl_arbiter #(
  parameter int ADDR_W    = 26,
  parameter int DATA_W    = 128,
  parameter int BL_W      = 9,
  parameter int TAG_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_write,
  input  logic                m1_write,
  input  logic                m0_read,
  input  logic                m1_read,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [BL_W-1:0]     m0_size,
  input  logic [BL_W-1:0]     m1_size,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W-1:0]   m1_wdata,
  output logic                m0_ready,
  output logic                m1_ready,
  output logic                m0_rdata_valid,
  output logic                m1_rdata_valid,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic [DATA_W-1:0]   m1_rdata,
  input  logic                avl_ready,
  output logic                avl_burstbegin,
  output logic [ADDR_W-1:0]   avl_addr,
  output logic [DATA_W-1:0]   avl_wdata,
  output logic [DATA_W/8-1:0] avl_be,
  output logic                avl_read_req,
  output logic                avl_write_req,
  output logic [BL_W-1:0]     avl_size,
  input  logic                avl_rdata_valid,
  input  logic [DATA_W-1:0]   avl_rdata,
  output logic                rd_orphan
);

  localparam int PTR_W = $clog2(TAG_DEPTH);

  typedef enum logic [1:0] {IDLE, WR, RD} state_t;

  state_t              state, state_nxt;
  logic                last_grant;
  logic                gnt;
  logic [ADDR_W-1:0]   addr_q;
  logic [BL_W-1:0]     size_q;
  logic [BL_W-1:0]     beat_cnt;
  logic                bb_q;

  logic                do_grant;
  logic                grant_port;
  logic [ADDR_W-1:0]   grant_addr;
  logic [BL_W-1:0]     grant_size;
  logic                elig0, elig1;
  logic                sel_write;
  logic [DATA_W-1:0]   sel_wdata;
  logic                rdy;
  logic                beat_acc;
  logic                burst_last;
  logic                push;

  logic                tag_port [TAG_DEPTH];
  logic [BL_W-1:0]     tag_size [TAG_DEPTH];
  logic [PTR_W:0]      wr_ptr, rd_ptr;
  logic                tag_empty, tag_full;
  logic                head_port;
  logic [BL_W-1:0]     head_size;
  logic [BL_W-1:0]     ret_cnt;
  logic                ret_beat;
  logic                pop;

  assign tag_empty = (wr_ptr == rd_ptr);
  assign tag_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign head_port = tag_port[rd_ptr[PTR_W-1:0]];
  assign head_size = tag_size[rd_ptr[PTR_W-1:0]];

  // A port's write request shadows its own read request.
  assign elig0 = m0_write || (m0_read && !tag_full);
  assign elig1 = m1_write || (m1_read && !tag_full);

  assign sel_write = gnt ? m1_write : m0_write;
  assign sel_wdata = gnt ? m1_wdata : m0_wdata;

  assign avl_be         = '1;
  assign avl_burstbegin = bb_q;
  assign avl_addr       = (state != IDLE) ? addr_q : '0;
  assign avl_size       = (state != IDLE) ? size_q : '0;
  assign m0_ready       = rdy && !gnt;
  assign m1_ready       = rdy && gnt;

  always_comb begin
    state_nxt     = state;
    do_grant      = 1'b0;
    grant_port    = 1'b0;
    grant_addr    = '0;
    grant_size    = '0;
    rdy           = 1'b0;
    beat_acc      = 1'b0;
    burst_last    = 1'b0;
    push          = 1'b0;
    avl_write_req = 1'b0;
    avl_read_req  = 1'b0;
    avl_wdata     = '0;
    case (state)
      IDLE: begin
        if (elig0 && elig1) grant_port = !last_grant;
        else                grant_port = elig1;
        do_grant   = elig0 || elig1;
        grant_addr = grant_port ? m1_addr : m0_addr;
        grant_size = grant_port ? m1_size : m0_size;
        if (grant_size == '0) grant_size = BL_W'(1);
        if (do_grant)
          state_nxt = (grant_port ? m1_write : m0_write) ? WR : RD;
      end
      WR: begin
        avl_write_req = sel_write;
        avl_wdata     = sel_wdata;
        rdy           = avl_ready && sel_write;
        beat_acc      = rdy;
        burst_last    = rdy && (beat_cnt == size_q - BL_W'(1));
        if (burst_last) state_nxt = IDLE;
      end
      RD: begin
        avl_read_req = 1'b1;
        rdy          = avl_ready;
        push         = avl_ready;
        if (avl_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Return path is independent of the command FSM.
  always_comb begin
    ret_beat       = avl_rdata_valid && !tag_empty;
    pop            = ret_beat && (ret_cnt == head_size - BL_W'(1));
    m0_rdata_valid = ret_beat && !head_port;
    m1_rdata_valid = ret_beat && head_port;
    m0_rdata       = m0_rdata_valid ? avl_rdata : '0;
    m1_rdata       = m1_rdata_valid ? avl_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt        <= 1'b0;
      addr_q     <= '0;
      size_q     <= '0;
      beat_cnt   <= '0;
      bb_q       <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ret_cnt    <= '0;
      rd_orphan  <= 1'b0;
    end else begin
      state <= state_nxt;
      bb_q  <= do_grant;
      if (do_grant) begin
        gnt        <= grant_port;
        last_grant <= grant_port;
        addr_q     <= grant_addr;
        size_q     <= grant_size;
      end
      if (beat_acc) beat_cnt <= burst_last ? '0 : beat_cnt + BL_W'(1);
      if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + (PTR_W+1)'(1);
        ret_cnt <= '0;
      end else if (ret_beat) begin
        ret_cnt <= ret_cnt + BL_W'(1);
      end
      if (avl_rdata_valid && tag_empty) rd_orphan <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      tag_port[wr_ptr[PTR_W-1:0]] <= gnt;
      tag_size[wr_ptr[PTR_W-1:0]] <= size_q;
    end
  end

endmodule
